// File: rtl/output_error_if.sv
// Handshake bundle for output_error_unit: y/t capture stream in, dz gradient stream out, batch loss report.
// master = the surrounding datapath/testbench, slave = the error unit.
interface output_error_if #(
    parameter int BITS = 16
) ();
    logic              y_valid;
    logic              y_ready;
    logic [BITS-1:0]   y_in;
    logic [BITS-1:0]   t_in;
    logic              dz_valid;
    logic              dz_ready;
    logic [BITS-1:0]   dz_out;
    logic [4:0]        dz_idx;
    logic              loss_valid;
    logic [2*BITS-1:0] loss_out;

    modport master (
        output y_valid, y_in, t_in, dz_ready,
        input  y_ready, dz_valid, dz_out, dz_idx, loss_valid, loss_out
    );

    modport slave (
        input  y_valid, y_in, t_in, dz_ready,
        output y_ready, dz_valid, dz_out, dz_idx, loss_valid, loss_out
    );
endinterface

// File: rtl/output_error_unit.sv
// Output error unit: captures N_OUT (y,t) pairs, streams dZ = y - t (saturated) and reports batch sum of e^2.
// Optional build macro OUTPUT_ERROR_RELU_MASK_EN zeroes dZ where y <= 0 (loss still uses the unmasked error).
module output_error_unit #(
    parameter int N_OUT = 2,
    parameter int BITS  = 16,
    parameter int FRAC  = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [CNT_W-1:0] batch_len,
    output_error_if.slave    bus
);
    typedef enum logic [0:0] {
        ST_CAPTURE = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    state_t              state_r;
    logic [4:0]          k_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    bl_r;
    logic [2*BITS-1:0]   acc_r;
    logic [BITS-1:0]     dz_mem_r [N_OUT];
    logic                y_ready_r;
    logic                dz_valid_r;
    logic [BITS-1:0]     dz_out_r;
    logic [4:0]          dz_idx_r;
    logic                loss_valid_r;
    logic [2*BITS-1:0]   loss_out_r;

    logic [BITS-1:0]     err_s;
    logic [BITS-1:0]     dz_new_s;
    logic [2*BITS-1:0]   sq_s;
    logic [2*BITS-1:0]   acc_sat_s;
    logic [BITS-1:0]     first_dz_s;
    logic [BITS-1:0]     nxt_dz_s;
    logic                accept_s;

    // y - t at BITS+1 bits, clamped back into the signed BITS range
    function automatic logic [BITS-1:0] sat_sub(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        logic [BITS:0] d;
        d = {a[BITS-1], a} - {b[BITS-1], b};
        if (d[BITS] != d[BITS-1]) begin
            sat_sub = d[BITS] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
        end else begin
            sat_sub = d[BITS-1:0];
        end
    endfunction

    function automatic logic [2*BITS-1:0] sat_add(input logic [2*BITS-1:0] a, input logic [2*BITS-1:0] b);
        logic [2*BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        sat_add = s[2*BITS] ? {(2*BITS){1'b1}} : s[2*BITS-1:0];
    endfunction

    // Error, squared error, accumulator update and next-dz selection
    always_comb begin
        logic signed [2*BITS-1:0] prod;
        accept_s  = bus.y_valid && y_ready_r;
        err_s     = sat_sub(bus.y_in, bus.t_in);
        prod      = $signed(err_s) * $signed(err_s);
        sq_s      = $unsigned(prod) >> FRAC;
        acc_sat_s = sat_add(acc_r, sq_s);
`ifdef OUTPUT_ERROR_RELU_MASK_EN
        dz_new_s  = (bus.y_in[BITS-1] || (bus.y_in == {BITS{1'b0}})) ? {BITS{1'b0}} : err_s;
`else
        dz_new_s  = err_s;
`endif
        // only reachable with k_r == 0 when N_OUT == 1: index 0 is being written this same edge
        first_dz_s = (k_r == 5'd0) ? dz_new_s : dz_mem_r[0];
        nxt_dz_s   = {BITS{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            nxt_dz_s = (i == int'(dz_idx_r) + 1) ? dz_mem_r[i] : nxt_dz_s;
        end
    end

    // Capture/emit FSM with batch loss bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_CAPTURE;
            k_r          <= 5'd0;
            cnt_r        <= {CNT_W{1'b0}};
            bl_r         <= {{(CNT_W-1){1'b0}}, 1'b1};
            acc_r        <= {(2*BITS){1'b0}};
            y_ready_r    <= 1'b1;
            dz_valid_r   <= 1'b0;
            dz_out_r     <= {BITS{1'b0}};
            dz_idx_r     <= 5'd0;
            loss_valid_r <= 1'b0;
            loss_out_r   <= {(2*BITS){1'b0}};
            for (int i = 0; i < N_OUT; i++) dz_mem_r[i] <= {BITS{1'b0}};
        end else if (flush) begin
            // partial sample and partial batch are discarded; the last reported loss stays visible
            state_r      <= ST_CAPTURE;
            k_r          <= 5'd0;
            cnt_r        <= {CNT_W{1'b0}};
            acc_r        <= {(2*BITS){1'b0}};
            y_ready_r    <= 1'b1;
            dz_valid_r   <= 1'b0;
            dz_out_r     <= {BITS{1'b0}};
            dz_idx_r     <= 5'd0;
            loss_valid_r <= 1'b0;
        end else begin
            loss_valid_r <= 1'b0;
            case (state_r)
                ST_CAPTURE: begin
                    if (accept_s) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (k_r == 5'(i)) dz_mem_r[i] <= dz_new_s;
                        end
                        acc_r <= acc_sat_s;
                        if ((k_r == 5'd0) && (cnt_r == {CNT_W{1'b0}})) begin
                            bl_r <= (batch_len == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : batch_len;
                        end
                        if (k_r == 5'(N_OUT-1)) begin
                            k_r        <= 5'd0;
                            state_r    <= ST_EMIT;
                            y_ready_r  <= 1'b0;
                            dz_valid_r <= 1'b1;
                            dz_idx_r   <= 5'd0;
                            dz_out_r   <= first_dz_s;
                        end else begin
                            k_r <= k_r + 5'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.dz_ready) begin
                        if (dz_idx_r == 5'(N_OUT-1)) begin
                            state_r    <= ST_CAPTURE;
                            y_ready_r  <= 1'b1;
                            dz_valid_r <= 1'b0;
                            dz_idx_r   <= 5'd0;
                            dz_out_r   <= {BITS{1'b0}};
                            if (cnt_r == bl_r - {{(CNT_W-1){1'b0}}, 1'b1}) begin
                                cnt_r        <= {CNT_W{1'b0}};
                                acc_r        <= {(2*BITS){1'b0}};
                                loss_out_r   <= acc_r;
                                loss_valid_r <= 1'b1;
                            end else begin
                                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            dz_idx_r <= dz_idx_r + 5'd1;
                            dz_out_r <= nxt_dz_s;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_CAPTURE;
                    k_r        <= 5'd0;
                    y_ready_r  <= 1'b1;
                    dz_valid_r <= 1'b0;
                    dz_idx_r   <= 5'd0;
                    dz_out_r   <= {BITS{1'b0}};
                end
            endcase
        end
    end

    assign bus.y_ready    = y_ready_r;
    assign bus.dz_valid   = dz_valid_r;
    assign bus.dz_out     = dz_out_r;
    assign bus.dz_idx     = dz_idx_r;
    assign bus.loss_valid = loss_valid_r;
    assign bus.loss_out   = loss_out_r;
endmodule

// File: tb/tb_output_error_unit.sv
// Directed bench for output_error_unit (N_OUT=2, Q8.8); expected values are hand-computed constants.
module tb_output_error_unit;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] batch_len = 8'd1;
    int         total = 0;
    int         bad = 0;

    output_error_if #(.BITS(16)) bus ();

    output_error_unit #(.N_OUT(2), .BITS(16), .FRAC(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .batch_len (batch_len),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one pair and hold it until accepted; returns #1 after the accepting edge
    task automatic send_pair(input logic [15:0] y, input logic [15:0] t);
        int n;
        n = 0;
        @(negedge clk);
        bus.y_valid = 1'b1;
        bus.y_in    = y;
        bus.t_in    = t;
        while (!bus.y_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("y_ready_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.y_valid = 1'b0;
    endtask

    // Accept one dz beat and check it; returns #1 after the handshake edge
    task automatic recv_dz(input string tag, input logic [15:0] exp_dz, input logic [4:0] exp_idx);
        int n;
        n = 0;
        @(negedge clk);
        bus.dz_ready = 1'b1;
        while (!bus.dz_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_timeout"}, 64'd0, 64'd1);
        chk({tag, "_dz"}, 64'(bus.dz_out), 64'(exp_dz));
        chk({tag, "_idx"}, 64'(bus.dz_idx), 64'(exp_idx));
        @(posedge clk);
        #1;
        bus.dz_ready = 1'b0;
    endtask

    task automatic sample(input logic [15:0] y0, input logic [15:0] t0, input logic [15:0] y1,
                          input logic [15:0] t1, input logic [15:0] dz0, input logic [15:0] dz1,
                          input string tag);
        send_pair(y0, t0);
        send_pair(y1, t1);
        recv_dz({tag, "0"}, dz0, 5'd0);
        recv_dz({tag, "1"}, dz1, 5'd1);
    endtask

    logic [15:0] exp_mask_dz;
    logic [15:0] exp_neg_dz;

    initial begin
        bus.y_valid  = 1'b0;
        bus.y_in     = 16'h0000;
        bus.t_in     = 16'h0000;
        bus.dz_ready = 1'b0;
`ifdef OUTPUT_ERROR_RELU_MASK_EN
        exp_mask_dz = 16'h0000;
        exp_neg_dz  = 16'h0000;
`else
        exp_mask_dz = 16'hFF00;
        exp_neg_dz  = 16'h8000;
`endif
        #12;
        chk("rst_y_ready", 64'(bus.y_ready), 64'd1);
        chk("rst_dz_valid", 64'(bus.dz_valid), 64'd0);
        chk("rst_dz_out", 64'(bus.dz_out), 64'd0);
        chk("rst_dz_idx", 64'(bus.dz_idx), 64'd0);
        chk("rst_loss_valid", 64'(bus.loss_valid), 64'd0);
        chk("rst_loss_out", 64'(bus.loss_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // basic sample, batch of one
        batch_len = 8'd1;
        send_pair(16'h0180, 16'h0100);
        send_pair(16'h0100, 16'h0100);
        chk("t1_latency_dz_valid", 64'(bus.dz_valid), 64'd1);
        chk("t1_latency_y_ready", 64'(bus.y_ready), 64'd0);
        recv_dz("t1_a", 16'h0080, 5'd0);
        recv_dz("t1_b", 16'h0000, 5'd1);
        chk("t1_loss_valid", 64'(bus.loss_valid), 64'd1);
        chk("t1_loss_out", 64'(bus.loss_out), 64'h0000_0040);
        chk("t1_y_ready_back", 64'(bus.y_ready), 64'd1);
        chk("t1_dz_valid_off", 64'(bus.dz_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("t1_loss_pulse_end", 64'(bus.loss_valid), 64'd0);
        chk("t1_loss_held", 64'(bus.loss_out), 64'h0000_0040);

        // saturation in both directions
        sample(16'h7F00, 16'h8100, 16'h8100, 16'h7F00, 16'h7FFF, exp_neg_dz, "t2_sat");
        chk("t2_loss_valid", 64'(bus.loss_valid), 64'd1);
        chk("t2_loss_out", 64'(bus.loss_out), 64'h0000_0000_007F_FF00);

        // ReLU mask case y=0
        sample(16'h0000, 16'h0100, 16'h0100, 16'h0100, exp_mask_dz, 16'h0000, "t3_mask");
        chk("t3_loss_out", 64'(bus.loss_out), 64'h0000_0100);

        // backpressure for 3 cycles in EMIT
        send_pair(16'h0200, 16'h0100);
        send_pair(16'h0100, 16'h0300);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(bus.dz_valid), 64'd1);
            chk("t4_hold_dz", 64'(bus.dz_out), 64'h0100);
            chk("t4_hold_idx", 64'(bus.dz_idx), 64'd0);
            chk("t4_hold_y_ready", 64'(bus.y_ready), 64'd0);
        end
        recv_dz("t4_a", 16'h0100, 5'd0);
        recv_dz("t4_b", 16'hFE00, 5'd1);
        chk("t4_loss_out", 64'(bus.loss_out), 64'h0000_0500);

        // batch of three; batch_len change mid-batch must be ignored
        batch_len = 8'd3;
        sample(16'h0180, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000, "t5_s0");
        chk("t5_s0_no_loss", 64'(bus.loss_valid), 64'd0);
        batch_len = 8'd1;
        sample(16'h0180, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000, "t5_s1");
        chk("t5_s1_no_loss", 64'(bus.loss_valid), 64'd0);
        chk("t5_s1_loss_held", 64'(bus.loss_out), 64'h0000_0500);
        sample(16'h0180, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000, "t5_s2");
        chk("t5_s2_loss_valid", 64'(bus.loss_valid), 64'd1);
        chk("t5_s2_loss_out", 64'(bus.loss_out), 64'h0000_00C0);

        // batch_len=0 acts as 1
        batch_len = 8'd0;
        sample(16'h0300, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0000, "t5_z");
        chk("t5_z_loss_valid", 64'(bus.loss_valid), 64'd1);
        chk("t5_z_loss_out", 64'(bus.loss_out), 64'h0000_0400);

        // async reset mid-EMIT
        batch_len = 8'd1;
        send_pair(16'h0180, 16'h0100);
        send_pair(16'h0300, 16'h0100);
        recv_dz("t6_pre", 16'h0080, 5'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_dz_valid", 64'(bus.dz_valid), 64'd0);
        chk("t6_rst_dz_idx", 64'(bus.dz_idx), 64'd0);
        chk("t6_rst_dz_out", 64'(bus.dz_out), 64'd0);
        chk("t6_rst_y_ready", 64'(bus.y_ready), 64'd1);
        chk("t6_rst_loss_out", 64'(bus.loss_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sample(16'h0180, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000, "t6_post");
        chk("t6_post_loss", 64'(bus.loss_out), 64'h0000_0040);

        // flush together with y_valid drops that pair
        @(negedge clk);
        flush       = 1'b1;
        bus.y_valid = 1'b1;
        bus.y_in    = 16'h7F00;
        bus.t_in    = 16'h8100;
        @(posedge clk);
        #1;
        flush       = 1'b0;
        bus.y_valid = 1'b0;
        sample(16'h0180, 16'h0100, 16'h0100, 16'h0100, 16'h0080, 16'h0000, "t6_flush");
        chk("t6_flush_loss_valid", 64'(bus.loss_valid), 64'd1);
        chk("t6_flush_loss", 64'(bus.loss_out), 64'h0000_0040);

        // long batch of saturated samples: accumulator must not wrap
        batch_len = 8'd255;
        for (int s = 0; s < 255; s++) begin
            sample(16'h7F00, 16'h8100, 16'h7F00, 16'h8100, 16'h7FFF, 16'h7FFF, "t2_long");
            if (s < 254) chk("t2_long_no_loss", 64'(bus.loss_valid), 64'd0);
        end
        chk("t2_long_loss_valid", 64'(bus.loss_valid), 64'd1);
        chk("t2_long_loss_out", 64'(bus.loss_out), 64'h0000_0000_7F7E_0200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
